wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback-stage consumer of the memory/writeback pipeline register. Each cycle it takes the registered memory-stage results (data-memory word, ALU result, destination index, control bits), extracts and sign/zero-extends load data, selects the writeback value, and commits it to a 32×32 integer register file. The register file supplies the decode stage through two bypassed read ports. The block also owns the sticky halt state and two performance counters.

## Interface
Parameters:
- XLEN, 32, datapath and register width
- NREG, 32, number of architectural registers; x0 is hardwired to zero

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- dm_out  in  32  data-memory read word, as registered by the M/W stage
- alu_out  in  32  ALU result; bits [1:0] are the load byte offset
- rd_index  in  5  destination register index
- halt  in  1  halt instruction is in writeback this cycle
- wb_sel  in  1  writeback source: 0 = alu_out, 1 = load data
- wb_en  in  1  register write request
- func3  in  3  load width/sign code
- rs1_index  in  5  read port 1 index
- rs2_index  in  5  read port 2 index
- rs1_data  out  32  read port 1 data (combinational)
- rs2_data  out  32  read port 2 data (combinational)
- wb_data  out  32  selected writeback value, used by the forwarding unit (combinational)
- wb_fire  out  1  a register write commits at this edge (combinational)
- halted  out  1  sticky halt flag (registered)
- cycle_cnt  out  32  cycles since reset while not halted
- wr_cnt  out  32  committed register writes

## Operation
- Load extraction is little-endian. off = alu_out[1:0].
  - func3 000 (lb): byte dm_out[8*off+7 : 8*off], sign-extended.
  - func3 100 (lbu): the same byte, zero-extended.
  - func3 001 (lh): halfword selected by off[1], sign-extended; off[0] is ignored.
  - func3 101 (lhu): the same halfword, zero-extended.
  - func3 010, 011, 110, 111: full dm_out (lw); off is ignored.
- wb_data = wb_sel ? load_data : alu_out. When wb_sel = 0, func3 has no effect.
- wb_fire = rst & wb_en & (rd_index != 0) & ~halt & ~halted.
  - A halt instruction never writes.
  - Once halted, all writes are suppressed.
- On wb_fire, regs[rd_index] <= wb_data at the rising edge.
- Read ports, evaluated independently for rs1 and rs2:
  - Index 0 returns 0.
  - Otherwise, if wb_fire and rd_index == rsN_index, return wb_data (write-through bypass).
  - Otherwise, return regs[rsN_index].
- Halt state machine, two states:
  - RUN (halted = 0): moves to HALT at the edge where halt = 1.
  - HALT (halted = 1): stays in HALT until reset.
- cycle_cnt increments at every edge while in RUN, including the edge where halt is sampled. It is frozen in HALT and wraps modulo 2^32.
- wr_cnt increments at every edge where wb_fire = 1 and wraps modulo 2^32.
- Reads remain fully functional in HALT.

## Timing
- Reset (rst = 0 at an edge) forces the following at that edge:
  - all regs = 0
  - halted = 0
  - cycle_cnt = 0
  - wr_cnt = 0
- Reset takes priority over every other event. A write presented during a reset cycle is dropped, and wb_fire = 0 while rst = 0.
- Write latency: the value is visible on a read port in the same cycle through the bypass, and from the array on the following cycle.
- halted rises one cycle after the cycle in which halt = 1.
- Simultaneous write and halt in the same cycle: no write, counters behave as in RUN for that edge, then freeze.
- rs1_index == rs2_index == rd_index with wb_fire: both ports return wb_data.
- No stalls or backpressure. One writeback is accepted every cycle.

## Test plan
- Reset, then write x5 = 0x12345678 (wb_sel = 0) -> rs1_data = 0x12345678 in the same cycle (bypass) and on the next cycle; wr_cnt = 1.
- Write x0 = 0xFFFFFFFF -> wb_fire = 0; reading x0 returns 0; wr_cnt unchanged.
- Load extraction with dm_out = 0x80FF7F01 and wb_sel = 1:
  - lb off = 3 -> 0xFFFFFF80
  - lbu off = 3 -> 0x00000080
  - lh off = 2 -> 0xFFFF80FF
  - lhu off = 0 -> 0x00007F01
  - lw off = 2 -> 0x80FF7F01
- Halt on cycle 10 with wb_en = 1, rd = 3:
  - x3 is unchanged.
  - halted = 1 from cycle 11.
  - cycle_cnt freezes at 11.
  - A later write to x4 is ignored, but reads still return stored values.
- Apply rst = 0 for one cycle while wb_en = 1, rd = 7, and x7 was previously written -> x7 = 0, all counters = 0, halted = 0.
- Write x9 = 0xA5A5A5A5 with rs1_index = rs2_index = 9 -> both read ports return 0xA5A5A5A5 in that cycle.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback stage: load extraction, writeback select, 32x32 regfile with bypassed reads, halt FSM, perf counters.
// Latency: wb_data, wb_fire and read ports are combinational; regs, halted and counters update at the next edge.
// Backpressure: none, one writeback is accepted every cycle.
module wb_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] dm_out,
  input  logic [XLEN-1:0] alu_out,
  input  logic [4:0]      rd_index,
  input  logic            halt,
  input  logic            wb_sel,
  input  logic            wb_en,
  input  logic [2:0]      func3,
  input  logic [4:0]      rs1_index,
  input  logic [4:0]      rs2_index,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_fire,
  output logic            halted,
  output logic [31:0]     cycle_cnt,
  output logic [31:0]     wr_cnt
);

  typedef enum logic {RUN, HALT} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] regs [NREG];
  logic [1:0]      off;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] load_data;

  assign off = alu_out[1:0];

  // Little-endian byte/halfword pick and sign/zero extension by load width code
  always_comb begin
    ld_byte   = 8'h00;
    ld_half   = off[1] ? dm_out[31:16] : dm_out[15:0];
    load_data = dm_out;
    case (off)
      2'd0: ld_byte = dm_out[7:0];
      2'd1: ld_byte = dm_out[15:8];
      2'd2: ld_byte = dm_out[23:16];
      default: ld_byte = dm_out[31:24];
    endcase
    case (func3)
      3'b000: load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100: load_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001: load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101: load_data = {{(XLEN-16){1'b0}}, ld_half};
      default: load_data = dm_out;
    endcase
  end

  assign wb_data = wb_sel ? load_data : alu_out;

  // A halt instruction, a halted core, x0 and reset all suppress the commit
  assign wb_fire = rst & wb_en & (rd_index != 5'd0) & ~halt & ~halted;

  // Read ports: x0 is zero, an in-flight commit to the same index is forwarded
  always_comb begin
    rs1_data = regs[rs1_index];
    rs2_data = regs[rs2_index];
    if (wb_fire && (rd_index == rs1_index)) rs1_data = wb_data;
    if (wb_fire && (rd_index == rs2_index)) rs2_data = wb_data;
    if (rs1_index == 5'd0) rs1_data = '0;
    if (rs2_index == 5'd0) rs2_data = '0;
  end

  // Register array commit; reset clears every entry
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_fire) begin
      regs[rd_index] <= wb_data;
    end
  end

  // Halt state register
  always_ff @(posedge clk) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  // Halt next-state: RUN leaves on halt, HALT is sticky until reset
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (halt) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  assign halted = (state == HALT);

  // Performance counters: cycles counted while running (including the halt edge), commits counted on fire
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_cnt <= '0;
      wr_cnt    <= '0;
    end else begin
      if (state == RUN) cycle_cnt <= cycle_cnt + 32'd1;
      if (wb_fire)      wr_cnt    <= wr_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus pushes model expectations, a negedge monitor pops and compares.
// Directed walk through loads, bypass, halt and reset, followed by a randomized phase.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] dm_out, alu_out;
  logic [4:0]  rd_index, rs1_index, rs2_index;
  logic        halt, wb_sel, wb_en;
  logic [2:0]  func3;
  logic [31:0] rs1_data, rs2_data, wb_data, cycle_cnt, wr_cnt;
  logic        wb_fire, halted;

  wb_regfile #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst), .dm_out(dm_out), .alu_out(alu_out), .rd_index(rd_index),
    .halt(halt), .wb_sel(wb_sel), .wb_en(wb_en), .func3(func3),
    .rs1_index(rs1_index), .rs2_index(rs2_index),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_data(wb_data), .wb_fire(wb_fire),
    .halted(halted), .cycle_cnt(cycle_cnt), .wr_cnt(wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fire;
    logic [31:0] wbd;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        hl;
    logic [31:0] cyc;
    logic [31:0] wr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;

  // Reference state
  logic [31:0] mreg [32];
  logic        m_halted;
  logic [31:0] m_cyc;
  logic [31:0] m_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Load value computed arithmetically from byte/halfword positions
  function automatic logic [31:0] mload(input logic [31:0] dm, input int off, input int f3);
    longint unsigned b, h;
    b = (longint'(dm) >> (8 * off)) % 256;
    h = (longint'(dm) >> (16 * (off / 2))) % 65536;
    case (f3)
      0: return (b >= 128) ? 32'(b - 256) : 32'(b);
      4: return 32'(b);
      1: return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      5: return 32'(h);
      default: return dm;
    endcase
  endfunction

  task automatic step(input logic r, input logic [31:0] dm, input logic [31:0] alu,
                      input logic [4:0] rd, input logic h, input logic sel, input logic en,
                      input logic [2:0] f3, input logic [4:0] i1, input logic [4:0] i2);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; dm_out = dm; alu_out = alu; rd_index = rd; halt = h;
    wb_sel = sel; wb_en = en; func3 = f3; rs1_index = i1; rs2_index = i2;
    e.wbd  = sel ? mload(dm, int'(alu % 4), int'(f3)) : alu;
    e.fire = r && en && (rd != 0) && !h && !m_halted;
    e.r1   = (i1 == 0) ? 32'h0 : ((e.fire && rd == i1) ? e.wbd : mreg[i1]);
    e.r2   = (i2 == 0) ? 32'h0 : ((e.fire && rd == i2) ? e.wbd : mreg[i2]);
    e.hl   = m_halted;
    e.cyc  = m_cyc;
    e.wr   = m_wr;
    sb.push_back(e);
    // Advance the model to the state after this edge
    if (!r) begin
      for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
      m_halted = 1'b0; m_cyc = 0; m_wr = 0;
    end else begin
      if (e.fire) begin
        mreg[rd] = e.wbd;
        m_wr = m_wr + 1;
      end
      if (!m_halted) begin
        m_cyc = m_cyc + 1;
        if (h) m_halted = 1'b1;
      end
    end
  endtask

  task automatic dchk(input string name, input logic [31:0] act_sel, input logic [31:0] exp);
    chk(name, act_sel, exp);
  endtask

  // Monitor: compare each cycle's outputs against the queued expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("wb_fire",   {31'h0, wb_fire}, {31'h0, e.fire});
      chk("wb_data",   wb_data, e.wbd);
      chk("rs1_data",  rs1_data, e.r1);
      chk("rs2_data",  rs2_data, e.r2);
      chk("halted",    {31'h0, halted}, {31'h0, e.hl});
      chk("cycle_cnt", cycle_cnt, e.cyc);
      chk("wr_cnt",    wr_cnt, e.wr);
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    m_halted = 1'b0; m_cyc = 0; m_wr = 0;
    rst = 1'b0; dm_out = 0; alu_out = 0; rd_index = 0; halt = 0;
    wb_sel = 0; wb_en = 0; func3 = 0; rs1_index = 0; rs2_index = 0;

    // cycle 0: x5 write with same-cycle bypass
    step(1, 32'h0, 32'h12345678, 5'd5, 0, 0, 1, 3'd0, 5'd5, 5'd0);
    @(negedge clk); dchk("bypass_x5", rs1_data, 32'h12345678);
    // cycle 1: array read of x5
    step(1, 32'h0, 32'h0, 5'd0, 0, 0, 0, 3'd0, 5'd5, 5'd5);
    @(negedge clk); dchk("array_x5", rs1_data, 32'h12345678);
    dchk("wr_cnt_1", wr_cnt, 32'd1);
    // cycle 2: x0 write is dropped
    step(1, 32'h0, 32'hFFFFFFFF, 5'd0, 0, 0, 1, 3'd0, 5'd0, 5'd0);
    @(negedge clk); dchk("x0_fire", {31'h0, wb_fire}, 32'h0);
    dchk("x0_read", rs1_data, 32'h0);
    // cycles 3..7: load extraction
    step(1, 32'h80FF7F01, 32'h3, 5'd3, 0, 1, 1, 3'b000, 5'd3, 5'd0);
    @(negedge clk); dchk("lb_off3", wb_data, 32'hFFFFFF80);
    step(1, 32'h80FF7F01, 32'h3, 5'd10, 0, 1, 1, 3'b100, 5'd3, 5'd10);
    @(negedge clk); dchk("lbu_off3", wb_data, 32'h00000080);
    step(1, 32'h80FF7F01, 32'h2, 5'd11, 0, 1, 1, 3'b001, 5'd10, 5'd0);
    @(negedge clk); dchk("lh_off2", wb_data, 32'hFFFF80FF);
    step(1, 32'h80FF7F01, 32'h0, 5'd12, 0, 1, 1, 3'b101, 5'd11, 5'd12);
    @(negedge clk); dchk("lhu_off0", wb_data, 32'h00007F01);
    step(1, 32'h80FF7F01, 32'h2, 5'd13, 0, 1, 1, 3'b010, 5'd12, 5'd13);
    @(negedge clk); dchk("lw_off2", wb_data, 32'h80FF7F01);
    // cycle 8: x9 with both ports on the written index
    step(1, 32'h0, 32'hA5A5A5A5, 5'd9, 0, 0, 1, 3'd0, 5'd9, 5'd9);
    @(negedge clk); dchk("dual_rs1", rs1_data, 32'hA5A5A5A5);
    dchk("dual_rs2", rs2_data, 32'hA5A5A5A5);
    // cycle 9: x7
    step(1, 32'h0, 32'hDEADBEEF, 5'd7, 0, 0, 1, 3'd0, 5'd7, 5'd0);
    // cycle 10: halt with write request to x3
    step(1, 32'h0, 32'h33333333, 5'd3, 1, 0, 1, 3'd0, 5'd3, 5'd0);
    @(negedge clk); dchk("halt_x3", rs1_data, 32'hFFFFFF80);
    // cycles 11,12: writes ignored, reads still live
    step(1, 32'h0, 32'h44444444, 5'd4, 0, 0, 1, 3'd0, 5'd4, 5'd3);
    step(1, 32'h0, 32'h0, 5'd0, 0, 0, 0, 3'd0, 5'd7, 5'd4);
    @(negedge clk); dchk("halted_1", {31'h0, halted}, 32'h1);
    dchk("cyc_frozen", cycle_cnt, 32'd11);
    dchk("wr_cnt_8", wr_cnt, 32'd8);
    dchk("x7_kept", rs1_data, 32'hDEADBEEF);
    dchk("x4_ignored", rs2_data, 32'h0);
    // Reset cycle with a pending write to x7
    step(0, 32'h0, 32'h77777777, 5'd7, 0, 0, 1, 3'd0, 5'd7, 5'd0);
    @(negedge clk); dchk("rst_fire", {31'h0, wb_fire}, 32'h0);
    step(1, 32'h0, 32'h0, 5'd0, 0, 0, 0, 3'd0, 5'd7, 5'd5);
    @(negedge clk); dchk("rst_x7", rs1_data, 32'h0);
    dchk("rst_x5", rs2_data, 32'h0);
    dchk("rst_cyc", cycle_cnt, 32'h0);
    dchk("rst_wr", wr_cnt, 32'h0);
    dchk("rst_halted", {31'h0, halted}, 32'h0);

    // Randomized phase
    for (int n = 0; n < 2000; n++) begin
      logic [4:0] rd, i1, i2;
      rd = 5'($urandom_range(0, 31));
      i1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      i2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 59) != 0), $urandom, $urandom, rd,
           ($urandom_range(0, 89) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)), i1, i2);
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
